// File: rtl/shf_seq_8bit.sv
// Iterative 8-bit shift/rotate unit: one bit position per clock, start/busy/done handshake.
// Shares opcode encoding with the combinational barrel shifter.
module shf_seq_8bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] oper,
  input  logic [7:0] x,
  input  logic [7:0] y,
  output logic [7:0] r,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state_r;
  logic [7:0] sreg_r;
  logic [2:0] cnt_r;
  logic [2:0] op_r;
  logic [7:0] r_r;
  logic       busy_r;
  logic       done_r;
  logic       err_r;
  logic       unused_y_s;

  // Only the low three bits of the shift amount are meaningful.
  assign unused_y_s = ^y[7:3];

  function automatic logic op_undef(input logic [2:0] op);
    case (op)
      3'b000, 3'b001, 3'b010, 3'b011, 3'b101: op_undef = 1'b0;
      default:                                op_undef = 1'b1;
    endcase
  endfunction

  function automatic logic [7:0] step1(input logic [2:0] op, input logic [7:0] v);
    case (op)
      3'b000:  step1 = {1'b0, v[7:1]};
      3'b001:  step1 = {v[7], v[7:1]};
      3'b010:  step1 = {v[0], v[7:1]};
      3'b011:  step1 = {v[6:0], 1'b0};
      3'b101:  step1 = {v[6:0], v[7]};
      default: step1 = v;
    endcase
  endfunction

  // Handshake FSM, working register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      sreg_r  <= 8'h00;
      cnt_r   <= 3'd0;
      op_r    <= 3'd0;
      r_r     <= 8'h00;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            sreg_r  <= x;
            // Undefined ops skip shifting so the operand passes through untouched.
            cnt_r   <= op_undef(oper) ? 3'd0 : y[2:0];
            op_r    <= oper;
            busy_r  <= 1'b1;
            state_r <= SHIFT;
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          if (cnt_r != 3'd0) begin
            sreg_r <= step1(op_r, sreg_r);
            cnt_r  <= cnt_r - 3'd1;
          end else begin
            r_r     <= sreg_r;
            err_r   <= op_undef(op_r);
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= DONE;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign r    = r_r;
  assign busy = busy_r;
  assign done = done_r;
  assign err  = err_r;

endmodule

// File: tb/tb_shf_seq_8bit.sv
// Directed and random checks of shf_seq_8bit against a closed-form shift/rotate model.
module tb_shf_seq_8bit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] oper = 3'd0;
  logic [7:0] x = 8'h00;
  logic [7:0] y = 8'h00;
  logic [7:0] r;
  logic       busy;
  logic       done;
  logic       err;

  int n_chk = 0;
  int n_bad = 0;

  shf_seq_8bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .oper  (oper),
    .x     (x),
    .y     (y),
    .r     (r),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic is_undef(input logic [2:0] o);
    return (o == 3'd4) || (o == 3'd6) || (o == 3'd7);
  endfunction

  function automatic logic [7:0] ref_r(input logic [2:0] o, input logic [7:0] v, input logic [2:0] n);
    logic signed [7:0] sv;
    logic [15:0]       d;
    sv = v;
    d  = {v, v};
    case (o)
      3'd0:    return v >> n;
      3'd1:    return 8'(sv >>> n);
      3'd2:    return 8'(d >> n);
      3'd3:    return 8'(v << n);
      3'd5: begin
        d = d << n;
        return d[15:8];
      end
      default: return v;
    endcase
  endfunction

  // Issue one op, measure latency/busy width, check result and single done pulse.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [7:0] xv,
                        input logic [7:0] yv, input logic [7:0] er, input logic ee,
                        input int elat, input bit spam);
    int lat;
    int busyc;
    int dcount;
    logic [7:0] rs;
    logic es;
    lat = 0; busyc = 0; dcount = 0; rs = 8'h00; es = 1'b0;
    @(negedge clk);
    oper = o; x = xv; y = yv; start = 1'b1;
    @(posedge clk); #1;
    if (spam) begin
      oper = 3'($urandom); x = 8'($urandom); y = 8'($urandom);
    end else begin
      start = 1'b0;
    end
    if (busy) busyc++;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (busy) busyc++;
      if (done) begin
        lat = k; dcount++; rs = r; es = err;
        break;
      end
      if (spam) begin
        oper = 3'($urandom); x = 8'($urandom); y = 8'($urandom);
      end
    end
    chk($sformatf("%s latency", tag), lat, elat);
    chk($sformatf("%s r", tag), rs, er);
    chk($sformatf("%s err", tag), es, ee);
    chk($sformatf("%s busy cycles", tag), busyc, elat);
    // Edge leaving DONE: start (if spammed) is still high and must be ignored.
    @(posedge clk); #1;
    start = 1'b0;
    chk($sformatf("%s done fall", tag), done, 1'b0);
    chk($sformatf("%s r held", tag), r, er);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    chk($sformatf("%s done count", tag), dcount, 1);
  endtask

  initial begin
    logic [2:0] o;
    logic [7:0] xv;
    logic [7:0] yv;
    logic       u;

    #12;
    chk("reset r", r, 8'h00);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset err", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("sra", 3'd1, 8'h96, 8'h03, 8'hF2, 1'b0, 4, 1'b0);
    run_op("ror", 3'd2, 8'h96, 8'h03, 8'hD2, 1'b0, 4, 1'b0);
    run_op("sll", 3'd3, 8'h96, 8'h02, 8'h58, 1'b0, 3, 1'b0);
    run_op("rol", 3'd5, 8'h81, 8'h01, 8'h03, 1'b0, 2, 1'b0);
    run_op("srl y ff", 3'd0, 8'h80, 8'hFF, 8'h01, 1'b0, 8, 1'b0);
    run_op("sra y0", 3'd1, 8'h5A, 8'h00, 8'h5A, 1'b0, 1, 1'b0);
    run_op("undef 110", 3'd6, 8'h3C, 8'h05, 8'h3C, 1'b1, 1, 1'b0);
    run_op("err clears", 3'd3, 8'h01, 8'h04, 8'h10, 1'b0, 5, 1'b0);
    run_op("srl spam", 3'd0, 8'hF0, 8'h05, 8'h07, 1'b0, 6, 1'b1);

    // Asynchronous reset between edges mid-SHIFT.
    @(negedge clk);
    oper = 3'd0; x = 8'hFF; y = 8'h05; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async rst busy", busy, 1'b0);
    chk("async rst done", done, 1'b0);
    chk("async rst err", err, 1'b0);
    chk("async rst r", r, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int dseen;
      dseen = 0;
      for (int k = 0; k < 10; k++) begin
        @(posedge clk); #1;
        if (done || busy) dseen++;
      end
      chk("no done after reset", dseen, 0);
    end
    run_op("after reset", 3'd5, 8'h96, 8'h04, 8'h69, 1'b0, 5, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      o  = 3'($urandom);
      xv = 8'($urandom);
      yv = 8'($urandom);
      u  = is_undef(o);
      run_op($sformatf("rand%0d op%0d x%0h y%0h", i, o, xv, yv), o, xv, yv,
             ref_r(o, xv, yv[2:0]), u, u ? 1 : int'(yv[2:0]) + 1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
